// File: rtl/conv_mac_pipe_if.sv
// conv_mac_pipe_if
//   Beat/result bundle for the pipelined convolution MAC.
//   Widths must match the parameters of the attached conv_mac_pipe.
//
//   Signals
//     in_valid  : din0/din1/in_first/in_last carry a beat (qualified by ce)
//     in_first  : beat opens a window
//     in_last   : beat closes a window
//     din0      : signed activation, DIN0_WIDTH
//     din1      : signed weight, DIN1_WIDTH
//     out_valid : dout/sat carry a window result (qualified by ce)
//     dout      : signed window result, DOUT_WIDTH
//     sat       : saturation occurred somewhere in the window
//
//   Modports
//     master : beat producer / result consumer (line buffer side)
//     slave  : the MAC itself
interface conv_mac_pipe_if #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 8,
  parameter int DOUT_WIDTH = 16
);
  logic                         in_valid;
  logic                         in_first;
  logic                         in_last;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         out_valid;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         sat;

  modport master (
    output in_valid, in_first, in_last, din0, din1,
    input  out_valid, dout, sat
  );

  modport slave (
    input  in_valid, in_first, in_last, din0, din1,
    output out_valid, dout, sat
  );
endinterface

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe
//   Pipelined signed multiply-accumulate with window framing. Each beat's
//   product is carried through an input register plus NUM_STAGE product
//   registers, accumulated with saturation, and on the closing beat of a
//   window the accumulator is arithmetically shifted, clamped to DOUT_WIDTH
//   and presented as a single-cycle result.
//
//   Parameters
//     DIN0_WIDTH : activation width (signed)
//     DIN1_WIDTH : weight width (signed)
//     ACC_WIDTH  : accumulator width, >= DIN0_WIDTH+DIN1_WIDTH
//     DOUT_WIDTH : result width, <= ACC_WIDTH
//     NUM_STAGE  : product register stages, >= 1
//     SHIFT      : arithmetic right shift before output clamp, 0..ACC_WIDTH-1
//
//   Ports
//     ap_clk : clock, rising edge
//     ap_rst : synchronous active-high reset, overrides ce
//     ce     : clock enable; all registers hold while low
//     bus    : beat inputs and result outputs (conv_mac_pipe_if.slave)
//
//   Latency: a closing beat sampled at ce edge k gives out_valid after
//   ce edge k+NUM_STAGE+1 (input register + NUM_STAGE + output register).
module conv_mac_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 16,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0
) (
  input logic           ap_clk,
  input logic           ap_rst,
  input logic           ce,
  conv_mac_pipe_if.slave bus
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int DW = DOUT_WIDTH;
  localparam int HW = AW - DW + 1;

  // ---------------------------------------------------------------------
  // Input register
  // ---------------------------------------------------------------------
  logic signed [DIN0_WIDTH-1:0] r_a;
  logic signed [DIN1_WIDTH-1:0] r_b;
  logic                         r_in_v;
  logic                         r_in_f;
  logic                         r_in_l;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_in_v <= 1'b0;
      r_in_f <= 1'b0;
      r_in_l <= 1'b0;
    end else if (ce) begin
      r_a    <= bus.din0;
      r_b    <= bus.din1;
      r_in_v <= bus.in_valid;
      r_in_f <= bus.in_first;
      r_in_l <= bus.in_last;
    end
  end

  // Operands sign-extended to full product width so the multiply is
  // self-determined at PW bits.
  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_prod;

  assign w_a_ext = {{DIN1_WIDTH{r_a[DIN0_WIDTH-1]}}, r_a};
  assign w_b_ext = {{DIN0_WIDTH{r_b[DIN1_WIDTH-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // ---------------------------------------------------------------------
  // Product pipeline: product travels with its valid/first/last tags
  // ---------------------------------------------------------------------
  logic signed [PW-1:0]  r_p [NUM_STAGE];
  logic [NUM_STAGE-1:0]  r_pv;
  logic [NUM_STAGE-1:0]  r_pf;
  logic [NUM_STAGE-1:0]  r_pl;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        r_p[i]  <= '0;
        r_pv[i] <= 1'b0;
        r_pf[i] <= 1'b0;
        r_pl[i] <= 1'b0;
      end
    end else if (ce) begin
      r_p[0]  <= w_prod;
      r_pv[0] <= r_in_v;
      r_pf[0] <= r_in_f;
      r_pl[0] <= r_in_l;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_p[i]  <= r_p[i-1];
        r_pv[i] <= r_pv[i-1];
        r_pf[i] <= r_pf[i-1];
        r_pl[i] <= r_pl[i-1];
      end
    end
  end

  logic signed [PW-1:0] w_p;
  logic                 w_v;
  logic                 w_first;
  logic                 w_last;

  assign w_p     = r_p[NUM_STAGE-1];
  assign w_v     = r_pv[NUM_STAGE-1];
  assign w_first = r_pf[NUM_STAGE-1];
  assign w_last  = r_pl[NUM_STAGE-1];

  // ---------------------------------------------------------------------
  // Accumulate with saturation
  // ---------------------------------------------------------------------
  logic signed [AW-1:0] r_acc;
  logic                 r_sat_acc;

  logic signed [AW:0]   w_p_ext;
  logic signed [AW:0]   w_base;
  logic signed [AW:0]   w_sum;
  logic                 w_acc_clip;
  logic signed [AW-1:0] w_acc_next;
  logic                 w_sat_acc_next;

  assign w_p_ext = {{(AW+1-PW){w_p[PW-1]}}, w_p};
  // A window opener starts from zero; otherwise the running sum is used.
  // After a close r_acc is already zero, so an unopened window also
  // starts from zero.
  assign w_base  = w_first ? '0 : {r_acc[AW-1], r_acc};
  assign w_sum   = w_base + w_p_ext;

  // AW+1-bit sum cannot itself overflow; the top two bits disagree
  // exactly when the result leaves the AW-bit range.
  assign w_acc_clip = w_sum[AW] ^ w_sum[AW-1];

  always_comb begin
    w_acc_next = w_sum[AW-1:0];
    if (w_acc_clip) begin
      if (w_sum[AW]) w_acc_next = {1'b1, {(AW-1){1'b0}}};
      else           w_acc_next = {1'b0, {(AW-1){1'b1}}};
    end
  end

  assign w_sat_acc_next = (w_first ? 1'b0 : r_sat_acc) | w_acc_clip;

  // ---------------------------------------------------------------------
  // Shift and output clamp
  // ---------------------------------------------------------------------
  logic signed [AW-1:0] w_shifted;
  logic [HW-1:0]        w_hi;
  logic                 w_out_clip;
  logic signed [DW-1:0] w_dout_next;

  assign w_shifted = w_acc_next >>> SHIFT;

  // Value fits DW bits when the bits above the result's sign bit are all
  // copies of it.
  assign w_hi       = w_shifted[AW-1:DW-1];
  assign w_out_clip = !((&w_hi) || !(|w_hi));

  always_comb begin
    w_dout_next = w_shifted[DW-1:0];
    if (w_out_clip) begin
      if (w_shifted[AW-1]) w_dout_next = {1'b1, {(DW-1){1'b0}}};
      else                 w_dout_next = {1'b0, {(DW-1){1'b1}}};
    end
  end

  // ---------------------------------------------------------------------
  // Accumulator state and output register
  // ---------------------------------------------------------------------
  logic                 r_out_valid;
  logic signed [DW-1:0] r_dout;
  logic                 r_sat;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_acc       <= '0;
      r_sat_acc   <= 1'b0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_sat       <= 1'b0;
    end else if (ce) begin
      r_out_valid <= 1'b0;
      if (w_v) begin
        if (w_last) begin
          r_acc       <= '0;
          r_sat_acc   <= 1'b0;
          r_dout      <= w_dout_next;
          r_sat       <= w_sat_acc_next | w_out_clip;
          r_out_valid <= 1'b1;
        end else begin
          r_acc     <= w_acc_next;
          r_sat_acc <= w_sat_acc_next;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_dout;
  assign bus.sat       = r_sat;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb_conv_mac_pipe
//   Three MAC instances share one beat stream: defaults, SHIFT=8, and a
//   24-bit accumulator/result. A reference model computes each window
//   result as beats are issued and queues it with the ce-cycle index of
//   the closing beat; monitors pop on every consumed out_valid and check
//   value, saturation flag and ce-relative latency.
module tb_conv_mac_pipe;
  localparam int NS = 3;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic ce     = 1'b0;

  logic              in_valid = 1'b0;
  logic              in_first = 1'b0;
  logic              in_last  = 1'b0;
  logic signed [15:0] din0    = '0;
  logic signed [7:0]  din1    = '0;

  always #5 ap_clk = ~ap_clk;

  conv_mac_pipe_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(8), .DOUT_WIDTH(16)) bus0 ();
  conv_mac_pipe_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(8), .DOUT_WIDTH(16)) bus1 ();
  conv_mac_pipe_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(8), .DOUT_WIDTH(24)) bus2 ();

  assign bus0.in_valid = in_valid; assign bus1.in_valid = in_valid; assign bus2.in_valid = in_valid;
  assign bus0.in_first = in_first; assign bus1.in_first = in_first; assign bus2.in_first = in_first;
  assign bus0.in_last  = in_last;  assign bus1.in_last  = in_last;  assign bus2.in_last  = in_last;
  assign bus0.din0     = din0;     assign bus1.din0     = din0;     assign bus2.din0     = din0;
  assign bus0.din1     = din1;     assign bus1.din1     = din1;     assign bus2.din1     = din1;

  conv_mac_pipe #(.NUM_STAGE(NS)) dut0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .bus(bus0));
  conv_mac_pipe #(.NUM_STAGE(NS), .SHIFT(8)) dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .bus(bus1));
  conv_mac_pipe #(.NUM_STAGE(NS), .ACC_WIDTH(24), .DOUT_WIDTH(24)) dut2 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .bus(bus2));

  typedef struct {
    longint dout;
    bit     sat;
    longint tag;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  exp_t   q2[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint ce_cnt   = 0;

  int     cfg_acc [3] = '{32, 32, 24};
  int     cfg_dout[3] = '{16, 16, 24};
  int     cfg_sh  [3] = '{0, 8, 0};

  longint m_acc[3]     = '{0, 0, 0};
  bit     m_sat[3]     = '{0, 0, 0};
  longint last_dout[3] = '{0, 0, 0};
  bit     last_sat[3]  = '{0, 0, 0};
  int     out_cnt[3]   = '{0, 0, 0};

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint clampv(input longint v, input int w, output bit clipped);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    clipped = 1'b0;
    if (v > hi) begin clipped = 1'b1; return hi; end
    if (v < lo) begin clipped = 1'b1; return lo; end
    return v;
  endfunction

  task automatic push_exp(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic model_beat(input longint p, input bit f, input bit l);
    longint sum, a, sh, d;
    bit     c1, c2, s;
    exp_t   e;
    for (int k = 0; k < 3; k++) begin
      sum = (f ? 64'sd0 : m_acc[k]) + p;
      a   = clampv(sum, cfg_acc[k], c1);
      s   = (f ? 1'b0 : m_sat[k]) | c1;
      if (l) begin
        sh     = a >>> cfg_sh[k];
        d      = clampv(sh, cfg_dout[k], c2);
        e.dout = d;
        e.sat  = s | c2;
        e.tag  = ce_cnt;
        push_exp(k, e);
        m_acc[k] = 0;
        m_sat[k] = 1'b0;
      end else begin
        m_acc[k] = a;
        m_sat[k] = s;
      end
    end
  endtask

  // Drive one cycle's inputs, let the edge sample them, then account for
  // the beat in the model.
  task automatic cycle(input bit v, input bit f, input bit l,
                       input logic signed [15:0] a, input logic signed [7:0] b,
                       input bit c);
    in_valid = v; in_first = f; in_last = l; din0 = a; din1 = b; ce = c;
    @(posedge ap_clk);
    if (c) begin
      ce_cnt++;
      if (v) model_beat(longint'(a) * longint'(b), f, l);
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 16'sd0, 8'sd0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    ap_rst = 1'b1; in_valid = 1'b0; ce = 1'b1;
    repeat (n) @(posedge ap_clk);
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) begin m_acc[k] = 0; m_sat[k] = 1'b0; end
    #1;
    ap_rst = 1'b0;
  endtask

  task automatic got(input int k, input longint d, input bit s);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_out[%0d]: got out_valid=1 dout=%0d, expected no output", k, d);
    end else begin
      check($sformatf("dout[%0d]", k), d, e.dout);
      check($sformatf("sat[%0d]", k), longint'(s), longint'(e.sat));
      check($sformatf("latency[%0d]", k), ce_cnt, e.tag + NS + 1);
    end
    last_dout[k] = d;
    last_sat[k]  = s;
    out_cnt[k]++;
  endtask

  always @(negedge ap_clk) begin
    if (!ap_rst && ce) begin
      if (bus0.out_valid) got(0, $signed(bus0.dout), bus0.sat);
      if (bus1.out_valid) got(1, $signed(bus1.dout), bus1.sat);
      if (bus2.out_valid) got(2, $signed(bus2.dout), bus2.sat);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bit rc, rv, rf, rl;
    logic signed [15:0] ra;
    logic signed [7:0]  rb;

    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_out_valid0", longint'(bus0.out_valid), 0);
    check("rst_dout0", longint'($signed(bus0.dout)), 0);
    check("rst_sat0", longint'(bus0.sat), 0);
    check("rst_out_valid1", longint'(bus1.out_valid), 0);
    check("rst_out_valid2", longint'(bus2.out_valid), 0);
    check("rst_dout2", longint'($signed(bus2.dout)), 0);
    ap_rst = 1'b0;
    idle(2);

    // Single term
    c0 = out_cnt[0];
    cycle(1, 1, 1, 16'sd300, -8'sd5, 1);
    idle(8);
    check("t1_count", out_cnt[0] - c0, 1);
    check("t1_dout", last_dout[0], -1500);
    check("t1_sat", longint'(last_sat[0]), 0);

    // Four-term window with a gap inside it
    c0 = out_cnt[0];
    cycle(1, 1, 0, 16'sd100, 8'sd2, 1);
    cycle(1, 0, 0, -16'sd50, 8'sd3, 1);
    idle(2);
    cycle(1, 0, 0, 16'sd7, 8'sd7, 1);
    cycle(1, 0, 1, 16'sd1000, -8'sd1, 1);
    idle(8);
    check("t2_count", out_cnt[0] - c0, 1);
    check("t2_dout", last_dout[0], -901);
    check("t2_sat", longint'(last_sat[0]), 0);

    // Output saturation, and the shifted variant
    cycle(1, 1, 1, -16'sd32768, -8'sd128, 1);
    idle(8);
    check("t3_dout", last_dout[0], 32767);
    check("t3_sat", longint'(last_sat[0]), 1);
    check("t3_shift_dout", last_dout[1], 16384);
    check("t3_shift_sat", longint'(last_sat[1]), 0);

    // Accumulator saturation on the 24-bit instance, then a clean window
    for (int i = 0; i < 8; i++)
      cycle(1, i == 0, i == 7, -16'sd32768, -8'sd128, 1);
    idle(8);
    check("t4_acc_dout", last_dout[2], 8388607);
    check("t4_acc_sat", longint'(last_sat[2]), 1);
    cycle(1, 1, 1, 16'sd10, 8'sd10, 1);
    idle(8);
    check("t4_next_dout", last_dout[2], 100);
    check("t4_next_sat", longint'(last_sat[2]), 0);

    // Stall mid-pipeline (junk beats while ce is low), then back-to-back
    c0 = out_cnt[0];
    cycle(1, 1, 1, 16'sd5, 8'sd5, 1);
    cycle(0, 0, 0, 16'sd0, 8'sd0, 1);
    repeat (3) cycle(1, 1, 1, 16'sd99, 8'sd99, 0);
    cycle(1, 1, 1, 16'sd5, 8'sd5, 1);
    cycle(1, 1, 1, 16'sd2, 8'sd3, 1);
    idle(8);
    check("t5_count", out_cnt[0] - c0, 3);
    check("t5_dout", last_dout[0], 6);

    // Reset mid-window
    c0 = out_cnt[0];
    cycle(1, 1, 0, 16'sd9, 8'sd9, 1);
    cycle(1, 0, 0, 16'sd9, 8'sd9, 1);
    do_reset(1);
    cycle(1, 0, 0, 16'sd9, 8'sd9, 1);
    cycle(1, 0, 1, 16'sd9, 8'sd9, 1);
    idle(8);
    check("t6_discard_count", out_cnt[0] - c0, 1);
    check("t6_discard_dout", last_dout[0], 162);
    c0 = out_cnt[0];
    cycle(1, 1, 1, 16'sd4, -8'sd4, 1);
    idle(8);
    check("t6_count", out_cnt[0] - c0, 1);
    check("t6_dout", last_dout[0], -16);

    // Randomised beats, framing, gaps and ce stalls
    for (int i = 0; i < 600; i++) begin
      rc = ($urandom_range(0, 4) != 0);
      rv = ($urandom_range(0, 3) != 0);
      rf = ($urandom_range(0, 3) == 0);
      rl = ($urandom_range(0, 3) == 0);
      ra = 16'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin ra = -16'sd32768; rb = -8'sd128; end
      cycle(rv, rf, rl, ra, rb, rc);
    end
    idle(12);
    check("drain_q0", longint'(q0.size()), 0);
    check("drain_q1", longint'(q1.size()), 0);
    check("drain_q2", longint'(q2.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
